reg_fifo: RTL and testbench



---
 rtl/reg_fifo.sv | 92 +++++++++
 tb/tb_reg_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_fifo.sv
// Synchronous register-based FIFO with value-plus-enable enqueue, ready/enable dequeue,
// occupancy count and sticky overflow/underflow flags.
module reg_fifo #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 2,
  parameter int unsigned cntw  = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] enq_in,
  input  logic             enq_en,
  output logic             enq_rdy,
  input  logic             deq_en,
  output logic             deq_rdy,
  output logic [width-1:0] first,
  output logic [cntw-1:0]  count,
  input  logic             err_clr,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cntw-1:0] CountFull = cntw'(depth);

  logic [width-1:0] mem [depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [cntw-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            enq_acc, deq_acc;

  // Full/empty come only from the count so pointer equality is never ambiguous.
  assign enq_rdy = (count_q != CountFull);
  assign deq_rdy = (count_q != '0);
  assign enq_acc = enq_en & enq_rdy;
  assign deq_acc = deq_en & deq_rdy;

  // Masking keeps unwritten storage from leaking X onto the head output.
  assign first = deq_rdy ? mem[rd_ptr_q] : '0;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (enq_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (deq_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({enq_acc, deq_acc})
      2'b10:   count_d = count_q + cntw'(1);
      2'b01:   count_d = count_q - cntw'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a violation in the same cycle wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (enq_en && !enq_rdy) ovf_d = 1'b1;
    if (deq_en && !deq_rdy) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq_acc && rst_n) mem[wr_ptr_q] <= enq_in;
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo (width 8, depth 4) with a queue-based reference model.
module tb_reg_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned C = $clog2(D + 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] enq_in;
  logic         enq_en;
  logic         enq_rdy;
  logic         deq_en;
  logic         deq_rdy;
  logic [W-1:0] first;
  logic [C-1:0] count;
  logic         err_clr;
  logic         ovf;
  logic         unf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q [$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  reg_fifo #(.width(W), .depth(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enq_in  (enq_in),
    .enq_en  (enq_en),
    .enq_rdy (enq_rdy),
    .deq_en  (deq_en),
    .deq_rdy (deq_rdy),
    .first   (first),
    .count   (count),
    .err_clr (err_clr),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_first;
    exp_first = (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0;
    check({tag, ".count"},   32'(count),   32'(exp_q.size()));
    check({tag, ".enq_rdy"}, 32'(enq_rdy), 32'(exp_q.size() != D));
    check({tag, ".deq_rdy"}, 32'(deq_rdy), 32'(exp_q.size() != 0));
    check({tag, ".first"},   32'(first),   exp_first);
    check({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    check({tag, ".unf"},     32'(unf),     32'(m_unf));
  endtask

  // One clock of stimulus; called at #1 after a rising edge, returns at #1 after the next.
  task automatic cycle(input string tag, input logic enq, input logic [W-1:0] data,
                       input logic deq, input logic clr);
    logic e_acc, d_acc;
    enq_in  = data;
    enq_en  = enq;
    deq_en  = deq;
    err_clr = clr;
    e_acc = enq && (exp_q.size() != D);
    d_acc = deq && (exp_q.size() != 0);
    if (d_acc) begin
      check({tag, ".pop"}, 32'(first), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (e_acc) exp_q.push_back(data);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (enq && !e_acc) m_ovf = 1'b1;
    if (deq && (d_acc == 1'b0)) m_unf = 1'b1;
    @(posedge clk);
    #1;
    enq_en  = 1'b0;
    deq_en  = 1'b0;
    err_clr = 1'b0;
    enq_in  = '0;
    check_state(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    enq_in  = '0;
    enq_en  = 1'b0;
    deq_en  = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Fill then drain.
    cycle("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around at occupancy 1.
    cycle("wrap_first", 1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 2; i <= 10; i++) cycle("wrap", 1'b1, W'(i), 1'b1, 1'b0);
    cycle("wrap_last", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous enq+deq while full.
    for (int i = 1; i <= 4; i++) cycle("refill", 1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    cycle("full_both", 1'b1, 8'h55, 1'b1, 1'b0);

    // Clear priority.
    cycle("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("top_up", 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("clr_vs_ovf", 1'b1, 8'h77, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous enq+deq while empty.
    cycle("empty_both", 1'b1, 8'h66, 1'b1, 1'b0);
    cycle("fill_a", 1'b1, 8'h67, 1'b0, 1'b0);
    cycle("fill_b", 1'b1, 8'h68, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with count 3.
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_state("async_rst");
    enq_en = 1'b1;
    enq_in = 8'h99;
    @(posedge clk);
    #1;
    enq_en = 1'b0;
    check_state("rst_held");
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
